seg7_scan_driver_param: RTL and testbench

// - Parametrised time-multiplexed 7-segment driver for NUM_DIGITS common-anode digits.
// - Adds the following over the fixed 4-digit driver:
//   - tear-free frame-synchronous value load
//   - per-digit decimal points
//   - leading-zero blanking
//   - PWM brightness
//   - anode dead-time against ghosting
// - Sits between the Binary-to-BCD converter and the board's anode/cathode pins.
//

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_glyph_decode.sv | 10 +
 rtl/seg7_scan_driver_param.sv | 89 ++++++++
 tb/tb_seg7_scan_driver_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low {g,f,e,d,c,b,a} glyph constants and BCD-to-segment lookup
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational digit-to-cathode pattern with blanking override
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  assign o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_digit);
endmodule

// File: rtl/seg7_scan_driver_param.sv
// seg7_scan_driver_param: multiplexed common-anode 7-segment driver with frame-synchronous
// load, leading-zero blanking, PWM brightness and anode dead-time
module seg7_scan_driver_param
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 4,
  parameter int DEAD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   seg_anode,
  output logic [6:0]              seg_cathode,
  output logic                    seg_dp,
  output logic                    frame_start
);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DEAD = DIV_W'(DEAD_CYC);
  logic [DIV_W-1:0]        r_presc;
  logic [SW-1:0]           r_slot;
  logic [4*NUM_DIGITS-1:0] r_sh_bcd, r_disp_bcd;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_disp_dp;
  logic                    r_pend;
  logic                    w_wrap, w_bound, w_on, w_zero, w_blank, w_dpsel;
  logic [BRIGHT_W-1:0]     w_phase;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg;
  assign w_wrap  = &r_presc;
  assign w_bound = w_wrap && r_slot == LAST;
  assign w_phase = r_presc[DIV_W-1 -: BRIGHT_W];
  assign w_on    = r_presc >= DEAD && w_phase <= bright;
  // walk from the most significant digit down so w_zero means "this digit and all above are 0"
  always_comb begin
    w_zero  = 1'b1;
    w_digit = '0;
    w_dpsel = 1'b0;
    w_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero = w_zero && r_disp_bcd[4*i +: 4] == 4'd0;
      if (r_slot == SW'(i)) begin
        w_digit = r_disp_bcd[4*i +: 4];
        w_dpsel = r_disp_dp[i];
        w_blank = blank_lz && i != 0 && w_zero;
      end
    end
  end
  seg7_glyph_decode u_glyph (
    .i_digit(w_digit),
    .i_blank(w_blank),
    .o_seg  (w_seg)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_presc     <= '0;
      r_slot      <= '0;
      r_sh_bcd    <= '0;
      r_sh_dp     <= '0;
      r_disp_bcd  <= '0;
      r_disp_dp   <= '0;
      r_pend      <= 1'b0;
      seg_anode   <= '1;
      seg_cathode <= SEG_BLANK;
      seg_dp      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_wrap) r_slot <= w_bound ? '0 : r_slot + 1'b1;
      if (w_bound && r_pend) begin
        r_disp_bcd <= r_sh_bcd;
        r_disp_dp  <= r_sh_dp;
      end
      if (load) begin
        r_sh_bcd <= bcd_in;
        r_sh_dp  <= dp_in;
      end
      r_pend      <= load || (r_pend && !w_bound);
      seg_anode   <= w_on ? ~(NUM_DIGITS'(1) << r_slot) : '1;
      seg_cathode <= w_seg;
      seg_dp      <= ~w_dpsel;
      frame_start <= w_bound;
    end
endmodule

// File: tb/tb_seg7_scan_driver_param.sv
// tb_seg7_scan_driver_param: arithmetic frame/slot model checked every cycle plus directed literal frames
module tb_seg7_scan_driver_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load, blank_lz;
  logic [1:0]  bright;
  logic [3:0]  seg_anode;
  logic [6:0]  seg_cathode;
  logic        seg_dp, frame_start;
  int tests = 0;
  int errs = 0;
  always #5 clk = ~clk;
  seg7_scan_driver_param #(.NUM_DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .DEAD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .bright(bright), .seg_anode(seg_anode),
    .seg_cathode(seg_cathode), .seg_dp(seg_dp), .frame_start(frame_start)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  // model: m_cnt edges since reset; slot length 16, frame length 64
  int          m_cnt;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dpd;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_cat;
  logic        e_dp, e_fs;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cnt = 0; m_sh = 0; m_disp = 0; m_shdp = 0; m_dpd = 0; m_pend = 0;
      e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      int p, s;
      p = m_cnt % 16;
      s = (m_cnt / 16) % 4;
      e_an  = (p >= 1 && p / 4 <= int'(bright)) ? ~(4'b0001 << s) : 4'hF;
      e_cat = (blank_lz && s > 0 && (m_disp >> (4 * s)) == 16'd0) ? 7'h7F : GL[m_disp[4*s +: 4]];
      e_dp  = ~m_dpd[s];
      e_fs  = (m_cnt % 64 == 63);
      if (m_cnt % 64 == 63 && m_pend) begin
        m_disp = m_sh; m_dpd = m_shdp; m_pend = 0;
      end
      if (load) begin
        m_sh = bcd_in; m_shdp = dp_in; m_pend = 1;
      end
      m_cnt++;
    end
  always @(negedge clk) begin
    chk("m_anode", seg_anode, e_an);
    chk("m_cathode", seg_cathode, e_cat);
    chk("m_dp", seg_dp, e_dp);
    chk("m_fs", frame_start, e_fs);
  end
  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (!frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) chk("fs_timeout", 0, 1);
  endtask
  // called at a frame_start negedge; returns at the next frame_start negedge
  task automatic check_frame(input string nm, input logic [27:0] cats, input logic [3:0] dps);
    logic [3:0] a;
    logic d;
    for (int s = 0; s < 4; s++) begin
      a = ~(4'b0001 << s);
      d = ~dps[s];
      @(negedge clk);
      chk({nm, "_dead"}, seg_anode, 4'hF);
      @(negedge clk);
      chk({nm, "_an"}, seg_anode, a);
      chk({nm, "_cat"}, seg_cathode, cats[7*s +: 7]);
      chk({nm, "_dp"}, seg_dp, d);
      repeat (14) @(negedge clk);
    end
  endtask
  task automatic load_val(input logic [15:0] v);
    bcd_in = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    int n;
    logic [15:0] mask;
    bcd_in = 0; dp_in = 0; load = 0; blank_lz = 0; bright = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_anode", seg_anode, 4'hF);
    chk("rst_cathode", seg_cathode, 7'h7F);
    chk("rst_dp", seg_dp, 1);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    dp_in = 4'b0100;
    load_val(16'h1234);
    dp_in = 4'b0000;
    wait_fs();
    check_frame("t1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100);
    blank_lz = 1'b1;
    load_val(16'h0070);
    wait_fs();
    check_frame("t2a", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0000);
    load_val(16'h0000);
    wait_fs();
    check_frame("t2b", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);
    load_val(16'h1111);
    wait_fs();
    repeat (20) @(negedge clk);
    load_val(16'hAAAA);
    repeat (13) @(negedge clk);
    chk("t3_old2", seg_cathode, 7'h79);
    repeat (16) @(negedge clk);
    chk("t3_old3", seg_cathode, 7'h79);
    wait_fs();
    check_frame("t3_dash", {4{7'h3F}}, 4'b0000);
    load_val(16'h5555);
    load_val(16'h6666);
    wait_fs();
    check_frame("t3_last", {4{7'h02}}, 4'b0000);
    load_val(16'h2222);
    n = 0;
    while (m_cnt % 64 != 63 && n < 100) begin
      @(negedge clk);
      n++;
    end
    load_val(16'h3333);
    chk("t4_fs", frame_start, 1);
    check_frame("t4_old", {4{7'h24}}, 4'b0000);
    check_frame("t4_new", {4{7'h30}}, 4'b0000);
    bright = 2'd0;
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (seg_anode != 4'hF) n++;
    end
    chk("t5_b0", n, 3);
    bright = 2'd2;
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (seg_anode != 4'hF) n++;
    end
    chk("t5_b2", n, 11);
    bright = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_anode", seg_anode, 4'hF);
    chk("t6_cathode", seg_cathode, 7'h7F);
    chk("t6_dp", seg_dp, 1);
    chk("t6_fs", frame_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fs();
    check_frame("t6_post", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);
    repeat (1500) begin
      @(negedge clk);
      mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
      bcd_in = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 29) == 0) bright = 2'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
